// File: rtl/fir_lpf_3tap.sv
// fir_lpf_3tap
// Three-tap FIR low-pass filter for an unsigned sample stream arriving one
// sample per clock. Output is the weighted sum
//   (COEF0*x[n] + COEF1*x[n-1] + COEF2*x[n-2]) >> SHIFT
// clamped to the sample range and registered, so each input sample reaches
// dout one clock after it is presented.
//
// Ports
//   clk    : sole clock, all state updates on its rising edge
//   rst_n  : synchronous reset, ACTIVE-HIGH despite the _n suffix; a 1 at a
//            rising edge clears the delay line and the output
//   din    : input sample (unsigned, DATA_W bits), taken every rising edge
//   dout   : filtered sample (unsigned, DATA_W bits), registered
module fir_lpf_3tap #(
  parameter int DATA_W = 8,
  parameter int COEF0  = 1,
  parameter int COEF1  = 2,
  parameter int COEF2  = 1,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Accumulator sized so the full weighted sum of three max-value samples
  // can never wrap, whatever the coefficients are.
  localparam int COEF_SUM = COEF0 + COEF1 + COEF2;
  localparam int ACC_W    = DATA_W + $clog2(COEF_SUM) + 1;

  localparam logic [ACC_W-1:0] K0 = ACC_W'(COEF0);
  localparam logic [ACC_W-1:0] K1 = ACC_W'(COEF1);
  localparam logic [ACC_W-1:0] K2 = ACC_W'(COEF2);

  localparam logic [DATA_W-1:0] SAT_MAX = '1;

  // Delay line: r_x1 holds x[n-1], r_x2 holds x[n-2].
  logic [DATA_W-1:0] r_x1;
  logic [DATA_W-1:0] r_x2;
  logic [DATA_W-1:0] r_dout;

  logic [ACC_W-1:0]  w_din_ext;
  logic [ACC_W-1:0]  w_x1_ext;
  logic [ACC_W-1:0]  w_x2_ext;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_shifted;
  logic [DATA_W-1:0] w_sat;

  // Zero-extend the samples to accumulator width before weighting so the
  // products and the sum are computed at full precision.
  assign w_din_ext = {{(ACC_W-DATA_W){1'b0}}, din};
  assign w_x1_ext  = {{(ACC_W-DATA_W){1'b0}}, r_x1};
  assign w_x2_ext  = {{(ACC_W-DATA_W){1'b0}}, r_x2};

  // The current sample enters the sum directly from din, paired with the
  // pre-edge contents of the delay line.
  assign w_sum     = (K0 * w_din_ext) + (K1 * w_x1_ext) + (K2 * w_x2_ext);

  // Truncating shift (floor division, no rounding).
  assign w_shifted = w_sum >> SHIFT;

  // Clamp when the shifted result does not fit in DATA_W bits. Unreachable
  // with the default [1,2,1]/4 weights but needed for other parameter sets.
  always_comb begin
    w_sat = w_shifted[DATA_W-1:0];
    if (w_shifted[ACC_W-1:DATA_W] != '0) begin
      w_sat = SAT_MAX;
    end
  end

  // Delay line and output register. Reset wipes all history so the first
  // output after reset sees x[n-1] = x[n-2] = 0; din is ignored while in
  // reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_x1   <= '0;
      r_x2   <= '0;
      r_dout <= '0;
    end else begin
      r_x1   <= din;
      r_x2   <= r_x1;
      r_dout <= w_sat;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_fir_lpf_3tap.sv
// tb_fir_lpf_3tap
// Directed testbench for fir_lpf_3tap with default parameters
// ([1,2,1]/4, 8-bit samples). Expected outputs are hand-computed constants
// or simple closed-form ramp values.
module tb_fir_lpf_3tap;

  logic       clk;
  logic       rstN;
  logic [7:0] din;
  logic [7:0] dout;

  int checkCount = 0;
  int errorCount = 0;

  fir_lpf_3tap dut (
    .clk   (clk),
    .rst_n (rstN),
    .din   (din),
    .dout  (dout)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample (and reset level) ahead of the next rising edge, then
  // wait for that edge and settle 1 unit past it before any sampling.
  task automatic applyStimulus(input logic [7:0] sample, input logic rst);
    din  = sample;
    rstN = rst;
    @(posedge clk);
    #1;
  endtask

  // Compare the registered output against a bench-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] expected);
    checkCount++;
    assert (dout === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: dout=%0d expected=%0d", tag, dout, expected);
    end
  endtask

  // Helper: one-edge reset followed by a check that the output is cleared.
  task automatic resetAndCheck(input string tag);
    applyStimulus(8'd0, 1'b1);
    checkOutput(tag, 8'd0);
  endtask

  initial begin
    logic [7:0] rampVal;
    int         expVal;

    din  = 8'd0;
    rstN = 1'b1;

    // Reset held for three edges with a nonzero din: output stays 0.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'd77, 1'b1);
      checkOutput($sformatf("resetHold%0d", i), 8'd0);
    end
    // Release with din=0: still 0.
    applyStimulus(8'd0, 1'b0);
    checkOutput("resetRelease0", 8'd0);
    applyStimulus(8'd0, 1'b0);
    checkOutput("resetRelease1", 8'd0);

    // Step response, din=100: 25, 75, 100, 100.
    resetAndCheck("stepReset");
    applyStimulus(8'd100, 1'b0); checkOutput("step1", 8'd25);
    applyStimulus(8'd100, 1'b0); checkOutput("step2", 8'd75);
    applyStimulus(8'd100, 1'b0); checkOutput("step3", 8'd100);
    applyStimulus(8'd100, 1'b0); checkOutput("step4", 8'd100);

    // Impulse of 200: 50, 100, 50, 0, 0.
    resetAndCheck("impReset");
    applyStimulus(8'd200, 1'b0); checkOutput("imp1", 8'd50);
    applyStimulus(8'd0,   1'b0); checkOutput("imp2", 8'd100);
    applyStimulus(8'd0,   1'b0); checkOutput("imp3", 8'd50);
    applyStimulus(8'd0,   1'b0); checkOutput("imp4", 8'd0);
    applyStimulus(8'd0,   1'b0); checkOutput("imp5", 8'd0);

    // Ramp +5 per clock through the 8-bit wrap (250, 255, 4).
    // Output 0: 0; output 1: 5>>2 = 1; then din-5; after din=4: 191.
    resetAndCheck("rampReset");
    for (int i = 0; i <= 52; i++) begin
      rampVal = 8'(i * 5);
      applyStimulus(rampVal, 1'b0);
      if (i == 0)       expVal = 0;
      else if (i == 1)  expVal = 1;
      else if (i == 52) expVal = 191;
      else              expVal = i * 5 - 5;
      checkOutput($sformatf("ramp%0d", i), 8'(expVal));
    end

    // Full-scale constant 255: 63, 191, 255, 255 (no overflow).
    resetAndCheck("fullReset");
    applyStimulus(8'd255, 1'b0); checkOutput("full1", 8'd63);
    applyStimulus(8'd255, 1'b0); checkOutput("full2", 8'd191);
    applyStimulus(8'd255, 1'b0); checkOutput("full3", 8'd255);
    applyStimulus(8'd255, 1'b0); checkOutput("full4", 8'd255);

    // Mid-stream reset: ramp up to 100, pulse reset for one edge, then
    // feed 100 again: 0, 25, 75, 100.
    resetAndCheck("midReset");
    for (int i = 0; i <= 20; i++) begin
      rampVal = 8'(i * 5);
      applyStimulus(rampVal, 1'b0);
    end
    checkOutput("midRampAt100", 8'd95);
    applyStimulus(8'd100, 1'b1); checkOutput("midPulse", 8'd0);
    applyStimulus(8'd100, 1'b0); checkOutput("midPost1", 8'd25);
    applyStimulus(8'd100, 1'b0); checkOutput("midPost2", 8'd75);
    applyStimulus(8'd100, 1'b0); checkOutput("midPost3", 8'd100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
